// File: rtl/johnson_pkg.sv
// Shared constants and pattern helpers for the Johnson counter.
// Build option: JOHNSON_SELF_CORRECT_EN (see johnson_counter_n).
package johnson_pkg;

  localparam int MAX_WIDTH = 16;

  // Pattern of phase p for a w-bit ring.
  function automatic logic [MAX_WIDTH-1:0]
    pat_encode(input int w, input int p);
    logic [MAX_WIDTH-1:0] r;
    int k;
    r = '0;
    k = p - w + 1;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) begin
        if (p < w)
          r[i] = (i >= w - 1 - p);
        else
          r[i] = (i < w - k);
      end
    end
    return r;
  endfunction

  // True when v is one of the 2*w legal patterns.
  function automatic logic
    is_legal(input int w,
             input logic [MAX_WIDTH-1:0] v);
    for (int p = 0; p < 2 * w; p++) begin
      if (v == pat_encode(w, p))
        return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/johnson_counter_n_decode.sv
// Pattern-to-phase decoder, purely combinational.
// Illegal patterns decode to phase 0.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             illegal
);

  logic [MAX_WIDTH-1:0] qf;
  logic [MAX_WIDTH-1:0] pf;

  // Zero-extend q for the legality check.
  always_comb begin
    qf = '0;
    qf[WIDTH-1:0] = q;
    illegal = ~is_legal(WIDTH, qf);
  end

  // Search the ring for the matching phase.
  always_comb begin
    phase = '0;
    pf = '0;
    for (int p = 0; p < 2 * WIDTH; p++) begin
      pf = pat_encode(WIDTH, p);
      if (q == pf[WIDTH-1:0])
        phase = PW'(p);
    end
  end

endmodule

// File: rtl/johnson_counter_n.sv
// Bidirectional Johnson counter with phase load.
// Define JOHNSON_SELF_CORRECT_EN to recover illegal states.
module johnson_counter_n
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam logic [MAX_WIDTH-1:0] P0F =
    pat_encode(WIDTH, 0);
  localparam logic [WIDTH-1:0] P0 =
    P0F[WIDTH-1:0];
  localparam logic [PW-1:0] LAST =
    PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     q_next;
  logic [WIDTH-1:0]     fwd;
  logic [WIDTH-1:0]     rev;
  logic [MAX_WIDTH-1:0] lpf;
  logic [PW-1:0]        ph;
  logic                 illegal;
  logic                 corr;

  johnson_phase_decode #(
    .WIDTH(WIDTH)
  ) u_dec (
    .q      (q_r),
    .phase  (ph),
    .illegal(illegal)
  );

`ifdef JOHNSON_SELF_CORRECT_EN
  assign corr = illegal;
  assign err  = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign corr = 1'b0;
  assign err  = 1'b0;
`endif

  assign fwd = {~q_r[0], q_r[WIDTH-1:1]};
  assign rev = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};

  // Out-of-range load phases fall back to phase 0.
  always_comb begin
    lpf = '0;
    if (int'(load_phase) < 2 * WIDTH)
      lpf = pat_encode(WIDTH, int'(load_phase));
    else
      lpf = P0F;
  end

  // Next-state mux: load, then recovery, then step.
  always_comb begin
    q_next = q_r;
    priority case (1'b1)
      load:      q_next = lpf[WIDTH-1:0];
      corr:      q_next = P0;
      en && up:  q_next = fwd;
      en && !up: q_next = rev;
      default:   q_next = q_r;
    endcase
  end

  // Pattern register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)
      q_r <= P0;
    else
      q_r <= q_next;
  end

  assign q     = q_r;
  assign phase = ph;
  assign wrap  = en & ~load & ~err &
                 (up ? (ph == LAST)
                     : (ph == '0));

endmodule
